axi_dma_wr_simple: RTL and testbench



---
 rtl/axi_dma_wr_pkg.sv | 21 ++
 rtl/axi_dma_wr_burst_calc.sv | 34 +++
 rtl/axi_dma_wr_simple.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_axi_dma_wr_simple.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_dma_wr_pkg.sv
// Shared types and AXI constants for the single-channel AXI write DMA.
package axi_dma_wr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

    localparam int unsigned BOUNDARY_4K = 4096;

endpackage

// File: rtl/axi_dma_wr_burst_calc.sv
// Combinational burst sizing: min(remaining words, max burst, words left before the 4 KB boundary).
module axi_dma_wr_burst_calc
    import axi_dma_wr_pkg::*;
#(
    parameter int unsigned AXI_STRB_WIDTH    = 4,
    parameter int unsigned AXI_MAX_BURST_LEN = 16,
    parameter int unsigned LEN_WIDTH         = 9
) (
    input  logic [11:0]          addr_low,
    input  logic [LEN_WIDTH-1:0] remaining,
    output logic [8:0]           beats
);

    localparam int unsigned OFF = $clog2(AXI_STRB_WIDTH);

    logic [12:0] to_4k_bytes;
    logic [31:0] to_4k_words;
    logic [31:0] pick;

    always_comb begin
        // addr is word-aligned, so the byte distance divides exactly
        to_4k_bytes = 13'(BOUNDARY_4K) - {1'b0, addr_low};
        to_4k_words = 32'(to_4k_bytes >> OFF);
        pick        = 32'(remaining);
        if (32'(AXI_MAX_BURST_LEN) < pick) begin
            pick = 32'(AXI_MAX_BURST_LEN);
        end
        if (to_4k_words < pick) begin
            pick = to_4k_words;
        end
        beats = 9'(pick);
    end

endmodule

// File: rtl/axi_dma_wr_simple.sv
// Single-channel AXI4 write DMA: one descriptor + one AXI-stream frame -> INCR bursts, one burst outstanding.
module axi_dma_wr_simple
    import axi_dma_wr_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH    = 32,
    parameter int unsigned AXI_ADDR_WIDTH    = 32,
    parameter int unsigned AXI_STRB_WIDTH    = AXI_DATA_WIDTH / 8,
    parameter int unsigned AXI_ID_WIDTH      = 8,
    parameter int unsigned AXI_MAX_BURST_LEN = 16,
    parameter int unsigned LEN_WIDTH         = 9
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [AXI_ADDR_WIDTH-1:0] s_axis_write_desc_addr,
    input  logic [LEN_WIDTH-1:0]      s_axis_write_desc_len,
    input  logic                      s_axis_write_desc_valid,
    output logic                      s_axis_write_desc_ready,

    output logic                      m_axis_write_desc_status_valid,
    output logic [LEN_WIDTH-1:0]      m_axis_write_desc_status_len,
    output logic [1:0]                m_axis_write_desc_status_error,

    input  logic [AXI_DATA_WIDTH-1:0] s_axis_write_data_tdata,
    input  logic                      s_axis_write_data_tvalid,
    output logic                      s_axis_write_data_tready,
    input  logic                      s_axis_write_data_tlast,

    output logic [AXI_ID_WIDTH-1:0]   m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awlock,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,

    output logic [AXI_DATA_WIDTH-1:0] m_axi_wdata,
    output logic [AXI_STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,

    input  logic [AXI_ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready
);

    localparam int unsigned OFF = $clog2(AXI_STRB_WIDTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_LOW_MASK = AXI_ADDR_WIDTH'(AXI_STRB_WIDTH - 1);

    state_t state, state_next;

    logic [AXI_ADDR_WIDTH-1:0] addr_reg;
    logic [LEN_WIDTH-1:0]      len_reg;
    logic [LEN_WIDTH-1:0]      words_aw;
    logic [LEN_WIDTH-1:0]      words_w;
    logic [LEN_WIDTH-1:0]      bytes;
    logic [AXI_STRB_WIDTH-1:0] last_strb;
    logic [8:0]                burst_beats;
    logic [8:0]                beat_cnt;
    logic [8:0]                calc_beats;
    logic                      tlast_seen;
    logic [1:0]                err;
    logic                      desc_ready_reg;
    logic                      status_valid_reg;
    logic [LEN_WIDTH-1:0]      status_len_reg;
    logic [1:0]                status_err_reg;

    logic                      desc_hs;
    logic                      w_hs;
    logic                      t_hs;
    logic                      status_fire;
    logic [LEN_WIDTH-1:0]      words_in;
    logic [LEN_WIDTH:0]        words_sum;
    logic [AXI_STRB_WIDTH-1:0] strb_in;
    logic [LEN_WIDTH:0]        bytes_sum;
    logic [LEN_WIDTH-1:0]      bytes_next;
    logic [1:0]                err_next;
    logic                      unused_bits;

    function automatic int unsigned popcount(input logic [AXI_STRB_WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < AXI_STRB_WIDTH; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    axi_dma_wr_burst_calc #(
        .AXI_STRB_WIDTH    (AXI_STRB_WIDTH),
        .AXI_MAX_BURST_LEN (AXI_MAX_BURST_LEN),
        .LEN_WIDTH         (LEN_WIDTH)
    ) u_burst_calc (
        .addr_low  (addr_reg[11:0]),
        .remaining (words_aw),
        .beats     (calc_beats)
    );

    assign unused_bits = ^m_axi_bid;

    assign m_axi_awid     = '0;
    assign m_axi_awaddr   = addr_reg;
    assign m_axi_awsize   = 3'(OFF);
    assign m_axi_awburst  = AXI_BURST_INCR;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awcache  = AXI_CACHE_DEFAULT;
    assign m_axi_awprot   = '0;

    assign s_axis_write_desc_ready        = desc_ready_reg;
    assign m_axis_write_desc_status_valid = status_valid_reg;
    assign m_axis_write_desc_status_len   = status_len_reg;
    assign m_axis_write_desc_status_error = status_err_reg;

    always_comb begin
        words_sum = {1'b0, s_axis_write_desc_len} + (LEN_WIDTH + 1)'(AXI_STRB_WIDTH - 1);
        words_in  = LEN_WIDTH'(words_sum >> OFF);
        strb_in   = '1;
        if (s_axis_write_desc_len[OFF-1:0] != '0) begin
            strb_in = ~(strb_in << s_axis_write_desc_len[OFF-1:0]);
        end
    end

    always_comb begin
        state_next               = state;
        m_axi_awvalid            = 1'b0;
        m_axi_awlen              = '0;
        m_axi_wvalid             = 1'b0;
        m_axi_wdata              = '0;
        m_axi_wstrb              = '0;
        m_axi_wlast              = 1'b0;
        m_axi_bready             = 1'b0;
        s_axis_write_data_tready = 1'b0;
        status_fire              = 1'b0;
        desc_hs                  = 1'b0;
        err_next                 = err;

        case (state)
            ST_IDLE: begin
                err_next = '0;
                desc_hs  = s_axis_write_desc_valid && desc_ready_reg;
                if (desc_hs) begin
                    if (s_axis_write_desc_len == '0) begin
                        status_fire = 1'b1;
                    end else begin
                        state_next = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                m_axi_awvalid = 1'b1;
                m_axi_awlen   = 8'(calc_beats - 9'd1);
                if (m_axi_awready) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                m_axi_wlast = (beat_cnt == burst_beats - 9'd1);
                // after an early tlast the burst is finished with zero-strobe pad beats
                if (tlast_seen) begin
                    m_axi_wvalid = 1'b1;
                end else begin
                    m_axi_wvalid             = s_axis_write_data_tvalid;
                    s_axis_write_data_tready = m_axi_wready;
                    m_axi_wdata              = s_axis_write_data_tdata;
                    m_axi_wstrb              = (words_w == LEN_WIDTH'(1)) ? last_strb : '1;
                end
                if (m_axi_wvalid && m_axi_wready && m_axi_wlast) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    err_next = {err[1], err[0] | (m_axi_bresp != AXI_RESP_OKAY)};
                    if (tlast_seen) begin
                        state_next  = ST_IDLE;
                        status_fire = 1'b1;
                    end else if (words_aw != '0) begin
                        state_next = ST_ADDR;
                    end else begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                s_axis_write_data_tready = 1'b1;
                if (s_axis_write_data_tvalid && s_axis_write_data_tlast) begin
                    state_next  = ST_IDLE;
                    status_fire = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign w_hs = m_axi_wvalid && m_axi_wready;
    assign t_hs = s_axis_write_data_tvalid && s_axis_write_data_tready;

    always_comb begin
        bytes_sum  = {1'b0, bytes} + (LEN_WIDTH + 1)'(popcount(m_axi_wstrb));
        bytes_next = (bytes_sum > {1'b0, len_reg}) ? len_reg : bytes_sum[LEN_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            addr_reg         <= '0;
            len_reg          <= '0;
            words_aw         <= '0;
            words_w          <= '0;
            bytes            <= '0;
            last_strb        <= '0;
            burst_beats      <= '0;
            beat_cnt         <= '0;
            tlast_seen       <= 1'b0;
            err              <= '0;
            desc_ready_reg   <= 1'b0;
            status_valid_reg <= 1'b0;
            status_len_reg   <= '0;
            status_err_reg   <= '0;
        end else begin
            state            <= state_next;
            desc_ready_reg   <= (state_next == ST_IDLE);
            status_valid_reg <= status_fire;
            if (status_fire) begin
                status_len_reg <= (state == ST_IDLE) ? '0 : bytes;
                status_err_reg <= err_next;
            end

            case (state)
                ST_IDLE: begin
                    if (desc_hs) begin
                        addr_reg   <= s_axis_write_desc_addr & ~ADDR_LOW_MASK;
                        len_reg    <= s_axis_write_desc_len;
                        words_aw   <= words_in;
                        words_w    <= words_in;
                        last_strb  <= strb_in;
                        bytes      <= '0;
                        tlast_seen <= 1'b0;
                        err        <= '0;
                    end
                end
                ST_ADDR: begin
                    if (m_axi_awready) begin
                        burst_beats <= calc_beats;
                        beat_cnt    <= '0;
                        words_aw    <= words_aw - LEN_WIDTH'(calc_beats);
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        bytes    <= bytes_next;
                        if (!tlast_seen) begin
                            words_w <= words_w - LEN_WIDTH'(1);
                        end
                    end
                    if (t_hs && s_axis_write_data_tlast) begin
                        tlast_seen <= 1'b1;
                        if (words_w != LEN_WIDTH'(1)) begin
                            err[1] <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (m_axi_bvalid) begin
                        err      <= err_next;
                        addr_reg <= addr_reg + (AXI_ADDR_WIDTH'(burst_beats) << OFF);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_dma_wr_simple.sv
// Directed scoreboard bench for axi_dma_wr_simple with a reactive AXI slave and stream source.
module tb_axi_dma_wr_simple;
    import axi_dma_wr_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;
    localparam int IW = 8;
    localparam int MB = 16;
    localparam int LW = 9;
    localparam int CAP = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [AW-1:0] desc_addr = '0;
    logic [LW-1:0] desc_len = '0;
    logic          desc_valid = 1'b0;
    logic          desc_ready;
    logic          st_valid;
    logic [LW-1:0] st_len;
    logic [1:0]    st_err;
    logic [DW-1:0] tdata = '0;
    logic          tvalid = 1'b0;
    logic          tready;
    logic          tlast = 1'b0;
    logic [IW-1:0] awid;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awlock;
    logic [3:0]    awcache;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready = 1'b0;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wlast;
    logic          wvalid;
    logic          wready = 1'b0;
    logic [IW-1:0] bid = '0;
    logic [1:0]    bresp = 2'b00;
    logic          bvalid = 1'b0;
    logic          bready;

    axi_dma_wr_simple #(
        .AXI_DATA_WIDTH    (DW),
        .AXI_ADDR_WIDTH    (AW),
        .AXI_STRB_WIDTH    (SW),
        .AXI_ID_WIDTH      (IW),
        .AXI_MAX_BURST_LEN (MB),
        .LEN_WIDTH         (LW)
    ) dut (
        .clk                            (clk),
        .rst                            (rst),
        .s_axis_write_desc_addr         (desc_addr),
        .s_axis_write_desc_len          (desc_len),
        .s_axis_write_desc_valid        (desc_valid),
        .s_axis_write_desc_ready        (desc_ready),
        .m_axis_write_desc_status_valid (st_valid),
        .m_axis_write_desc_status_len   (st_len),
        .m_axis_write_desc_status_error (st_err),
        .s_axis_write_data_tdata        (tdata),
        .s_axis_write_data_tvalid       (tvalid),
        .s_axis_write_data_tready       (tready),
        .s_axis_write_data_tlast        (tlast),
        .m_axi_awid                     (awid),
        .m_axi_awaddr                   (awaddr),
        .m_axi_awlen                    (awlen),
        .m_axi_awsize                   (awsize),
        .m_axi_awburst                  (awburst),
        .m_axi_awlock                   (awlock),
        .m_axi_awcache                  (awcache),
        .m_axi_awprot                   (awprot),
        .m_axi_awvalid                  (awvalid),
        .m_axi_awready                  (awready),
        .m_axi_wdata                    (wdata),
        .m_axi_wstrb                    (wstrb),
        .m_axi_wlast                    (wlast),
        .m_axi_wvalid                   (wvalid),
        .m_axi_wready                   (wready),
        .m_axi_bid                      (bid),
        .m_axi_bresp                    (bresp),
        .m_axi_bvalid                   (bvalid),
        .m_axi_bready                   (bready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // captures written only by the slave/monitor process
    logic [AW-1:0] cap_aw_addr [CAP];
    logic [7:0]    cap_aw_len  [CAP];
    int            cap_aw_cyc  [CAP];
    logic [DW-1:0] cap_w_data  [CAP];
    logic [SW-1:0] cap_w_strb  [CAP];
    logic          cap_w_last  [CAP];
    int            cap_b_cyc   [CAP];
    logic [LW-1:0] cap_st_len  [CAP];
    logic [1:0]    cap_st_err  [CAP];
    int            cap_st_cyc  [CAP];
    int n_aw = 0, n_w = 0, n_b = 0, n_st = 0, n_t = 0;
    int cyc = 0, t_last_cyc = 0, desc_cyc = 0, stab_err = 0;
    bit b_pend = 0, w_hold = 0, b_hs = 0;
    logic [DW-1:0] h_data;
    logic [SW-1:0] h_strb;

    // slave configuration, written only by the stimulus block
    bit bp = 0;
    int err_at_b = -1;

    typedef struct { logic [AW-1:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [DW-1:0] data; logic [SW-1:0] strb; logic last; } w_t;
    typedef struct { logic [LW-1:0] len; logic [1:0] err; bit drain; } st_t;
    aw_t exp_aw[$];
    w_t  exp_w[$];
    st_t exp_st[$];

    always begin
        @(negedge clk);
        cyc++;
        b_hs = 0;
        if (rst) begin
            b_pend = 0;
            w_hold = 0;
            awready = 0;
            wready = 0;
            bvalid = 0;
        end else begin
            if (awvalid && awready) begin
                cap_aw_addr[n_aw] = awaddr;
                cap_aw_len[n_aw]  = awlen;
                cap_aw_cyc[n_aw]  = cyc;
                n_aw++;
            end
            if (w_hold && (!wvalid || wdata !== h_data || wstrb !== h_strb)) stab_err++;
            w_hold = wvalid && !wready;
            h_data = wdata;
            h_strb = wstrb;
            if (wvalid && wready) begin
                cap_w_data[n_w] = wdata;
                cap_w_strb[n_w] = wstrb;
                cap_w_last[n_w] = wlast;
                n_w++;
                if (wlast) b_pend = 1;
            end
            if (bvalid && bready) begin
                cap_b_cyc[n_b] = cyc;
                n_b++;
                b_hs = 1;
            end
            if (tvalid && tready) begin
                n_t++;
                if (tlast) t_last_cyc = cyc;
            end
            if (desc_valid && desc_ready) desc_cyc = cyc;
            if (st_valid) begin
                cap_st_len[n_st] = st_len;
                cap_st_err[n_st] = st_err;
                cap_st_cyc[n_st] = cyc;
                n_st++;
            end
        end
        @(posedge clk);
        #1;
        awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        wready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (b_hs) bvalid = 0;
        if (b_pend && !bvalid && !rst) begin
            bvalid = 1;
            bresp  = (n_b == err_at_b) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            b_pend = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int tid, input int idx);
        return 32'hA500_0000 ^ (32'(tid) << 16) ^ 32'(idx * 7 + 1);
    endfunction

    task automatic model(input logic [AW-1:0] addr, input int len, input int frame, input int err_burst, input int tid);
        int words, w, bi, n, b4, bytes, idx;
        logic [AW-1:0] a;
        logic [SW-1:0] lm, s;
        logic [DW-1:0] d;
        bit early, stop, e0;
        words = (len + SW - 1) / SW;
        a = addr & ~AW'(SW - 1);
        w = 0; bi = 0; bytes = 0; stop = 0; e0 = 0;
        early = frame < words;
        lm = (len % SW == 0) ? 4'hF : 4'((1 << (len % SW)) - 1);
        while (w < words && !stop) begin
            n = words - w;
            if (n > MB) n = MB;
            b4 = (4096 - int'(a % 4096)) / SW;
            if (b4 < n) n = b4;
            exp_aw.push_back('{a, 8'(n - 1)});
            for (int k = 0; k < n; k++) begin
                idx = w + k;
                if (idx < frame) begin
                    s = (idx == words - 1) ? lm : 4'hF;
                    d = beat_data(tid, idx);
                end else begin
                    s = '0;
                    d = '0;
                end
                exp_w.push_back('{d, s, k == n - 1});
                bytes += $countones(s);
                if (early && idx == frame - 1) stop = 1;
            end
            if (bi == err_burst) e0 = 1;
            w += n;
            a += AW'(n * SW);
            bi++;
        end
        exp_st.push_back('{LW'(bytes), {early, e0}, frame > words});
    endtask

    task automatic send_desc(input logic [AW-1:0] addr, input int len);
        bit ok = 0;
        desc_addr  = addr;
        desc_len   = LW'(len);
        desc_valid = 1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (desc_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        chk("desc_handshake", 64'(ok), 64'd1);
        @(posedge clk); #1;
        desc_valid = 0;
    endtask

    task automatic send_frame(input int tid, input int frame, input int nsend);
        bit ok;
        for (int i = 0; i < nsend; i++) begin
            if (bp && $urandom_range(0, 2) == 0) begin
                tvalid = 0;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            tvalid = 1;
            tdata  = beat_data(tid, i);
            tlast  = (i == frame - 1);
            ok = 0;
            for (int t = 0; t < 500; t++) begin
                @(negedge clk);
                if (tready) begin ok = 1; break; end
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            if (!ok) begin
                chk("stream_beat_timeout", 64'(i), 64'(nsend));
                break;
            end
        end
        tvalid = 0;
        tlast  = 0;
    endtask

    task automatic run_xfer(input string name, input logic [AW-1:0] addr, input int len, input int frame,
                            input int err_burst, input int tid, input bit bp_en);
        int aw0, w0, b0, st0, t0, naw, nw, i;
        bit ok = 0;
        aw_t ea;
        w_t ew;
        st_t es;
        aw0 = n_aw; w0 = n_w; b0 = n_b; st0 = n_st; t0 = n_t;
        bp = bp_en;
        err_at_b = (err_burst < 0) ? -1 : n_b + err_burst;
        model(addr, len, frame, err_burst, tid);
        naw = exp_aw.size();
        nw  = exp_w.size();
        send_desc(addr, len);
        if (frame > 0) send_frame(tid, frame, frame);
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk); #1;
            if (n_st > st0) begin ok = 1; break; end
        end
        chk({name, ":status_seen"}, 64'(ok), 64'd1);
        repeat (3) begin @(posedge clk); #1; end

        chk({name, ":aw_count"}, 64'(n_aw - aw0), 64'(naw));
        i = aw0;
        while (exp_aw.size() > 0) begin
            ea = exp_aw.pop_front();
            chk({name, ":awaddr"}, 64'(cap_aw_addr[i]), 64'(ea.addr));
            chk({name, ":awlen"}, 64'(cap_aw_len[i]), 64'(ea.len));
            if (i > aw0) chk({name, ":aw_after_b"}, 64'(cap_aw_cyc[i] > cap_b_cyc[b0 + i - aw0 - 1]), 64'd1);
            i++;
        end
        if (!bp_en && len > 0) chk({name, ":aw_latency"}, 64'(cap_aw_cyc[aw0]), 64'(desc_cyc + 1));

        chk({name, ":w_count"}, 64'(n_w - w0), 64'(nw));
        i = w0;
        while (exp_w.size() > 0) begin
            ew = exp_w.pop_front();
            chk({name, ":wdata"}, 64'(cap_w_data[i]), 64'(ew.data));
            chk({name, ":wstrb"}, 64'(cap_w_strb[i]), 64'(ew.strb));
            chk({name, ":wlast"}, 64'(cap_w_last[i]), 64'(ew.last));
            i++;
        end

        chk({name, ":stream_beats"}, 64'(n_t - t0), 64'(frame));
        chk({name, ":status_pulses"}, 64'(n_st - st0), 64'd1);
        es = exp_st.pop_front();
        chk({name, ":status_len"}, 64'(cap_st_len[st0]), 64'(es.len));
        chk({name, ":status_err"}, 64'(cap_st_err[st0]), 64'(es.err));
        if (len == 0)
            chk({name, ":status_time"}, 64'(cap_st_cyc[st0]), 64'(desc_cyc + 1));
        else if (es.drain)
            chk({name, ":status_time"}, 64'(cap_st_cyc[st0]), 64'(t_last_cyc + 1));
        else
            chk({name, ":status_time"}, 64'(cap_st_cyc[st0]), 64'(cap_b_cyc[n_b - 1] + 1));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ":desc_ready"}, 64'(desc_ready), 64'd0);
        chk({name, ":awvalid"}, 64'(awvalid), 64'd0);
        chk({name, ":wvalid"}, 64'(wvalid), 64'd0);
        chk({name, ":tready"}, 64'(tready), 64'd0);
        chk({name, ":bready"}, 64'(bready), 64'd0);
        chk({name, ":status_valid"}, 64'(st_valid), 64'd0);
        chk({name, ":awaddr"}, 64'(awaddr), 64'd0);
        chk({name, ":awlen"}, 64'(awlen), 64'd0);
        chk({name, ":wdata"}, 64'(wdata), 64'd0);
        chk({name, ":wstrb"}, 64'(wstrb), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int st0;
        bit ok;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset:status_len", 64'(st_len), 64'd0);
        chk("reset:status_err", 64'(st_err), 64'd0);
        chk("reset:awsize", 64'(awsize), 64'd2);
        chk("reset:awburst", 64'(awburst), 64'(AXI_BURST_INCR));
        chk("reset:awcache", 64'(awcache), 64'(AXI_CACHE_DEFAULT));
        rst = 0;
        #1;
        chk("post_reset:desc_ready_low", 64'(desc_ready), 64'd0);
        @(posedge clk); #1;
        chk("post_reset:desc_ready_high", 64'(desc_ready), 64'd1);

        run_xfer("base",      32'h0000_1000,  64, 16, -1, 1, 0);
        run_xfer("partial",   32'h0000_2000,   6,  2, -1, 2, 0);
        run_xfer("split4k",   32'h0000_0FF8,  32,  8, -1, 3, 0);
        run_xfer("early",     32'h0000_1000,  64,  4, -1, 4, 0);
        run_xfer("long",      32'h0000_3000,   8,  5, -1, 5, 0);
        run_xfer("slverr",    32'h0000_5000,  40, 10,  0, 6, 0);
        run_xfer("unaligned", 32'h0000_2003,   8,  2, -1, 7, 0);
        run_xfer("len0",      32'h0000_7000,   0,  0, -1, 8, 0);
        run_xfer("bp_a",      32'h0000_3F80, 100, 25, -1, 9, 1);
        run_xfer("bp_b",      32'h0000_0FC0, 200, 50,  1, 10, 1);
        run_xfer("bp_c",      32'h0000_8004,  37,  7, -1, 11, 1);

        bp = 0;
        err_at_b = -1;
        st0 = n_st;
        send_desc(32'h0000_6000, 64);
        send_frame(12, 16, 3);
        tvalid = 1;
        tdata  = beat_data(12, 3);
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            if (wvalid) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        chk("rst_mid:wvalid_before", 64'(ok), 64'd1);
        rst = 1;
        #1;
        chk_all_zero("rst_mid");
        tvalid = 0;
        @(posedge clk); #1;
        rst = 0;
        repeat (6) begin @(posedge clk); #1; end
        chk("rst_mid:no_status", 64'(n_st - st0), 64'd0);
        chk("rst_mid:desc_ready", 64'(desc_ready), 64'd1);

        run_xfer("after_rst", 32'h0000_9000, 12, 3, -1, 13, 0);
        chk("w_stability_violations", 64'(stab_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
